// File: rtl/vram_arbiter.sv
// Three-port arbiter for the shared 16-bit video SRAM: fixed/round-robin grant
// selection with a starvation override, strobe sequencing and write turnaround.
module vram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic [5:0]            be,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_din,
  output logic [DATA_W-1:0]     ram_dout,
  output logic                  ram_ce,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic                  ram_lb,
  output logic                  ram_hb
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_p2;
  logic [7:0]          r_wait;
  logic [2:0]          r_vld_p1;

  logic                w_any;
  logic [1:0]          w_sel;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [1:0]          w_sel_be;

  // Grant selection: starvation override, then port 0, then round-robin 1/2.
  // Nothing issues in WRITE, and reset suppresses acceptance on that edge.
  always_comb begin
    w_any = 1'b0;
    w_sel = 2'd0;
    if (reset_n && r_state != S_WRITE) begin
      if (req[2] && r_wait == MAX_W8) begin
        w_any = 1'b1;
        w_sel = 2'd2;
      end else if (req[0]) begin
        w_any = 1'b1;
        w_sel = 2'd0;
      end else if (req[1] && !(req[2] && r_rr_p2)) begin
        w_any = 1'b1;
        w_sel = 2'd1;
      end else if (req[2]) begin
        w_any = 1'b1;
        w_sel = 2'd2;
      end
    end
  end

  always_comb begin
    w_sel_we    = we[2];
    w_sel_addr  = addr[2*ADDR_W +: ADDR_W];
    w_sel_wdata = wdata[2*DATA_W +: DATA_W];
    w_sel_be    = be[5:4];
    case (w_sel)
      2'd0: begin
        w_sel_we    = we[0];
        w_sel_addr  = addr[0 +: ADDR_W];
        w_sel_wdata = wdata[0 +: DATA_W];
        w_sel_be    = be[1:0];
      end
      2'd1: begin
        w_sel_we    = we[1];
        w_sel_addr  = addr[ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[DATA_W +: DATA_W];
        w_sel_be    = be[3:2];
      end
      default: ;
    endcase
  end

  assign gnt = w_any ? (3'b001 << w_sel) : 3'b000;

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_any)
      w_state_nxt = w_sel_we ? S_WRITE : S_READ;
    else if (r_state == S_WRITE)
      w_state_nxt = S_TURN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rr_p2 <= 1'b0;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (gnt[1])
        r_rr_p2 <= 1'b1;
      else if (gnt[2])
        r_rr_p2 <= 1'b0;
      if (req[2] && !gnt[2])
        r_wait <= (r_wait == MAX_W8) ? r_wait : r_wait + 8'd1;
      else
        r_wait <= 8'd0;
    end
  end

  // Stage p1: drive SRAM address/strobes for the access granted last cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_dout <= '0;
      ram_ce   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_we   <= 1'b0;
      ram_lb   <= 1'b0;
      ram_hb   <= 1'b0;
      r_vld_p1 <= 3'b000;
    end else begin
      ram_ce   <= w_any;
      ram_oe   <= w_any && !w_sel_we;
      ram_we   <= w_any && w_sel_we;
      ram_lb   <= w_any && (w_sel_we ? w_sel_be[0] : 1'b1);
      ram_hb   <= w_any && (w_sel_we ? w_sel_be[1] : 1'b1);
      r_vld_p1 <= (w_any && !w_sel_we) ? gnt : 3'b000;
      if (w_any)
        ram_addr <= w_sel_addr;
      if (w_any && w_sel_we)
        ram_dout <= w_sel_wdata;
    end
  end

  // Stage p2: capture SRAM read data and tag it with the requesting port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid <= 3'b000;
      rdata  <= '0;
    end else begin
      rvalid <= r_vld_p1;
      if (|r_vld_p1)
        rdata <= ram_din;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic, all
// checked against a rule-level reference model of grants and SRAM cycles.
module tb_vram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int MW = 15;
  localparam int OW = AW + DW + 5 + 3 + DW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [5:0]      be;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic [AW-1:0]   ram_addr;
  logic            ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct { int due; int port; } rd_t;
  rd_t           rdq[$];
  int            m_wait;
  int            m_rr;
  bit            m_prev_wr;
  logic [2:0]    exp_gnt;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_dout, e_rdata;
  logic          e_ce, e_oe, e_we, e_lb, e_hb;
  logic [2:0]    e_rvalid;

  logic [OW-1:0] obs, expv;
  assign obs  = {ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, rvalid, rdata};
  assign expv = {e_addr, e_dout, e_ce, e_oe, e_we, e_lb, e_hb, e_rvalid, e_rdata};

  // Called between edges: decides this cycle's grant from the rules and
  // predicts the registered outputs after the coming edge.
  task automatic model_tick();
    int g;
    g = -1;
    if (!reset_n) begin
      exp_gnt = 3'b000; m_wait = 0; m_rr = 1; m_prev_wr = 0; rdq.delete();
      e_addr = '0; e_dout = '0; e_rdata = '0; e_rvalid = 3'b000;
      e_ce = 0; e_oe = 0; e_we = 0; e_lb = 0; e_hb = 0;
      return;
    end
    if (!m_prev_wr) begin
      if (req[2] && m_wait == MW) g = 2;
      else if (req[0]) g = 0;
      else if (req[1] && req[2]) g = m_rr;
      else if (req[1]) g = 1;
      else if (req[2]) g = 2;
    end
    exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
    if (req[2] && g != 2) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else m_wait = 0;
    if (g == 1) m_rr = 2;
    else if (g == 2) m_rr = 1;
    e_rvalid = 3'b000;
    if (rdq.size() > 0 && rdq[0].due == cyc + 1) begin
      e_rvalid = 3'(1 << rdq[0].port);
      e_rdata  = ram_din;
      void'(rdq.pop_front());
    end
    e_ce = 0; e_oe = 0; e_we = 0; e_lb = 0; e_hb = 0;
    m_prev_wr = 0;
    if (g >= 0) begin
      e_addr = addr[g*AW +: AW];
      e_ce   = 1;
      if (we[g]) begin
        e_we = 1; e_dout = wdata[g*DW +: DW];
        e_lb = be[2*g]; e_hb = be[2*g+1];
        m_prev_wr = 1;
      end else begin
        e_oe = 1; e_lb = 1; e_hb = 1;
        rdq.push_back('{due: cyc + 2, port: g});
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_tick();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    ram_din = 16'($urandom);
  endtask

  task automatic set_port(input int i, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] b);
    req[i] = r; we[i] = w;
    addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; be[2*i +: 2] = b;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++)
      set_port(i, 1'b1, 1'($urandom), 18'($urandom), 16'($urandom), 2'($urandom));
    for (int k = 0; k < 2; k++) begin
      to_neg();
      n_checks++;
      if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt);
      else n_pass++;
      to_pos();
      n_checks++;
      if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs);
      else n_pass++;
    end
    req = 3'b000;
    reset_n = 1'b1;
    to_neg(); to_pos();
  endtask

  task automatic test_single_read();
    set_port(0, 1'b1, 1'b0, 18'h02040, 16'h0, 2'b11);
    to_neg();
    n_checks++;
    if (gnt !== 3'b001) $display("FAIL single_gnt: got %b want 001", gnt);
    else n_pass++;
    to_pos();
    req = 3'b000;
    ram_din = 16'hA5C3;
    n_checks++;
    if ({ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !== {18'h02040, 5'b11011})
      $display("FAIL single_issue: got addr=%h ce/oe/we/lb/hb=%b%b%b%b%b want addr=02040 11011",
               ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb);
    else n_pass++;
    to_neg(); to_pos();
    n_checks++;
    if (rvalid !== 3'b001 || rdata !== 16'hA5C3)
      $display("FAIL single_resp: got rvalid=%b rdata=%h want 001 a5c3", rvalid, rdata);
    else n_pass++;
    n_checks++;
    if (obs !== expv) $display("FAIL single_model: got %h want %h", obs, expv);
    else n_pass++;
  endtask

  task automatic test_p0_starves_p1();
    set_port(0, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
    set_port(1, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
    for (int k = 0; k < 16; k++) begin
      if (k == 10) req[0] = 1'b0;
      to_neg();
      n_checks++;
      if (gnt !== ((k < 10) ? 3'b001 : 3'b010))
        $display("FAIL p0_priority[%0d]: got %b want %b", k, gnt, (k < 10) ? 3'b001 : 3'b010);
      else n_pass++;
      to_pos();
      n_checks++;
      if (obs !== expv) $display("FAIL p0_priority_out[%0d]: got %h want %h", k, obs, expv);
      else n_pass++;
      if (k < 10) addr[0 +: AW] = 18'($urandom);
      else addr[AW +: AW] = 18'($urandom);
    end
    req = 3'b000;
    to_neg(); to_pos();
  endtask

  task automatic test_round_robin();
    int last;
    last = -1;
    set_port(1, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
    set_port(2, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
    for (int k = 0; k < 12; k++) begin
      if (k == 5) set_port(0, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
      to_neg();
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
      else n_pass++;
      n_checks++;
      if (k == 5) begin
        if (gnt !== 3'b001) $display("FAIL rr_p0_cut[%0d]: got %b want 001", k, gnt);
        else n_pass++;
      end else if (!(gnt == 3'b010 || gnt == 3'b100) ||
                   (last == 1 && gnt !== 3'b100) || (last == 2 && gnt !== 3'b010)) begin
        $display("FAIL rr_alternate[%0d]: got %b after port %0d", k, gnt, last);
      end else begin
        n_pass++;
        last = gnt[1] ? 1 : 2;
      end
      to_pos();
      n_checks++;
      if (obs !== expv) $display("FAIL rr_out[%0d]: got %h want %h", k, obs, expv);
      else n_pass++;
      for (int i = 0; i < 3; i++)
        if (exp_gnt[i]) addr[i*AW +: AW] = 18'($urandom);
      if (k == 5) req[0] = 1'b0;
    end
    req = 3'b000;
    to_neg(); to_pos();
  endtask

  task automatic test_starvation();
    for (int r = 0; r < 2; r++) begin
      int hit;
      hit = -1;
      set_port(0, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
      set_port(2, 1'b1, 1'b0, 18'($urandom), 16'h0, 2'b11);
      for (int k = 0; k < 20 && hit < 0; k++) begin
        to_neg();
        n_checks++;
        if (gnt !== exp_gnt) $display("FAIL starve_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
        else n_pass++;
        if (gnt[2]) hit = k;
        to_pos();
        n_checks++;
        if (obs !== expv) $display("FAIL starve_out[%0d]: got %h want %h", k, obs, expv);
        else n_pass++;
        addr[0 +: AW] = 18'($urandom);
      end
      n_checks++;
      if (hit != MW) $display("FAIL starve_cycle[%0d]: got %0d want %0d", r, hit, MW);
      else n_pass++;
    end
    req = 3'b000;
    to_neg(); to_pos();
    to_neg(); to_pos();
  endtask

  task automatic test_write_turn();
    set_port(2, 1'b1, 1'b1, 18'h05010, 16'hBEEF, 2'b10);
    to_neg();
    n_checks++;
    if (gnt !== 3'b100) $display("FAIL wr_gnt: got %b want 100", gnt);
    else n_pass++;
    to_pos();
    req[2] = 1'b0;
    set_port(0, 1'b1, 1'b0, 18'h00111, 16'h0, 2'b11);
    n_checks++;
    if ({ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !==
        {18'h05010, 16'hBEEF, 5'b10101})
      $display("FAIL wr_issue: got addr=%h dout=%h ce/oe/we/lb/hb=%b%b%b%b%b want 05010 beef 10101",
               ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb);
    else n_pass++;
    to_neg();
    n_checks++;
    if (gnt !== 3'b000) $display("FAIL wr_no_gnt_in_write: got %b want 000", gnt);
    else n_pass++;
    to_pos();
    n_checks++;
    if ({ram_ce, ram_we, ram_dout} !== {2'b00, 16'hBEEF})
      $display("FAIL wr_turn: got ce=%b we=%b dout=%h want 0 0 beef", ram_ce, ram_we, ram_dout);
    else n_pass++;
    to_neg();
    n_checks++;
    if (gnt !== 3'b001) $display("FAIL wr_gnt_in_turn: got %b want 001", gnt);
    else n_pass++;
    to_pos();
    req = 3'b000;
    n_checks++;
    if (obs !== expv) $display("FAIL wr_read_after: got %h want %h", obs, expv);
    else n_pass++;
    to_neg(); to_pos();
    to_neg(); to_pos();
  endtask

  task automatic test_reset_midread();
    set_port(1, 1'b1, 1'b0, 18'h1ABCD, 16'h0, 2'b11);
    to_neg();
    n_checks++;
    if (gnt !== 3'b010) $display("FAIL rst_mid_gnt: got %b want 010", gnt);
    else n_pass++;
    to_pos();
    req = 3'b000;
    reset_n = 1'b0;
    to_neg(); to_pos();
    n_checks++;
    if (obs !== '0) $display("FAIL rst_mid_drop: got %h want 0", obs);
    else n_pass++;
    reset_n = 1'b1;
    set_port(1, 1'b1, 1'b0, 18'h00321, 16'h0, 2'b11);
    set_port(2, 1'b1, 1'b0, 18'h00654, 16'h0, 2'b11);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      n_checks++;
      if (gnt !== exp_gnt || (k == 0 && gnt !== 3'b010))
        $display("FAIL rst_after_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
      else n_pass++;
      to_pos();
      n_checks++;
      if (obs !== expv) $display("FAIL rst_after_out[%0d]: got %h want %h", k, obs, expv);
      else n_pass++;
      req = req & ~exp_gnt;
    end
    req = 3'b000;
    to_neg(); to_pos();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      to_neg();
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL rand_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
      else n_pass++;
      to_pos();
      n_checks++;
      if (obs !== expv) $display("FAIL rand_out[%0d]: got %h want %h", k, obs, expv);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
        if (exp_gnt[i]) req[i] = 1'b0;
        if (req[i] && $urandom_range(15) == 0)
          req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) != 0)
          set_port(i, 1'b1, ($urandom_range(3) == 0), 18'($urandom), 16'($urandom), 2'($urandom));
      end
    end
    req = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req = 3'b000; we = 3'b000; addr = '0; wdata = '0; be = '0;
    ram_din = '0;
    m_wait = 0; m_rr = 1; m_prev_wr = 0; exp_gnt = 3'b000;
    e_addr = '0; e_dout = '0; e_rdata = '0; e_rvalid = 3'b000;
    e_ce = 0; e_oe = 0; e_we = 0; e_lb = 0; e_hb = 0;
    #1;
    test_reset();
    test_single_read();
    test_p0_starves_p1();
    test_round_robin();
    test_starvation();
    test_write_turn();
    test_reset_midread();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
